// File: rtl/pdp8_mem_pkg.sv
// Shared types for the PDP-8 memory arbiter: widths, DMA FSM states, op encoding.
`timescale 1ns/1ps
package pdp8_mem_pkg;

  localparam int ADDR_W = 15;
  localparam int WORD_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_DONE    = 2'd2,
    ST_RELEASE = 2'd3
  } dma_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } dma_op_e;

  typedef struct packed {
    dma_op_e             op;
    logic [ADDR_W-1:0]   ma;
    logic [WORD_W-1:0]   wdata;
  } dma_req_t;

  // Width of a counter that must hold 0..cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pdp8_mem_arb_if.sv
// CPU, DMA and RAM bus bundle around the arbiter; slave = arbiter view, master = surroundings.
`timescale 1ns/1ps
interface pdp8_mem_arb_if
  import pdp8_mem_pkg::*;
#(
  parameter int PCNT_W = 8
);

  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_rd;
  logic              cpu_wr;

  logic              dma_read_req;
  logic              dma_write_req;
  logic [ADDR_W-1:0] dma_ma;
  logic [WORD_W-1:0] dma_wdata;
  logic [WORD_W-1:0] dma_rdata;
  logic              dma_done;
  logic              dma_busy;
  logic [PCNT_W-1:0] preempt_count;

  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic              ram_rd;
  logic              ram_wr;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    input  dma_read_req, dma_write_req, dma_ma, dma_wdata,
    input  ram_rdata,
    output cpu_rdata, dma_rdata, dma_done, dma_busy, preempt_count,
    output ram_addr, ram_wdata, ram_rd, ram_wr
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    output dma_read_req, dma_write_req, dma_ma, dma_wdata,
    output ram_rdata,
    input  cpu_rdata, dma_rdata, dma_done, dma_busy, preempt_count,
    input  ram_addr, ram_wdata, ram_rd, ram_wr
  );

endinterface

// File: rtl/pdp8_mem_arb.sv
// CPU/DMA arbiter for the single pdp8_ram: CPU passes through with zero latency,
// DMA uses idle slots, restarts on preemption and pulses dma_done when complete.
`timescale 1ns/1ps
module pdp8_mem_arb
  import pdp8_mem_pkg::*;
#(
  parameter int RAM_CYCLES = 2,
  parameter int PCNT_W     = 8
) (
  input  logic            clk,
  input  logic            reset,
  pdp8_mem_arb_if.slave   bus
);

  localparam int              CNT_W    = cnt_width(RAM_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_CYCLES - 1);

  if (RAM_CYCLES < 1 || RAM_CYCLES > 15) begin : g_bad_ram_cycles
    $error("pdp8_mem_arb: RAM_CYCLES must be in 1..15");
  end

  dma_state_e        state;
  logic [CNT_W-1:0]  cnt;
  dma_req_t          req_q;
  logic [WORD_W-1:0] rdata_q;
  logic              done_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic              cpu_act_q;
  logic              entry_q;

  logic cpu_act;
  logic any_req;
  logic preempt_first;

  assign cpu_act = bus.cpu_rd | bus.cpu_wr;
  assign any_req = bus.dma_read_req | bus.dma_write_req;

  // A preemption episode is counted once: on ACCESS entry or on a CPU rising edge.
  assign preempt_first = (state == ST_ACCESS) && cpu_act && (entry_q || !cpu_act_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req_q     <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      pcnt_q    <= '0;
      cpu_act_q <= 1'b0;
      entry_q   <= 1'b0;
    end else begin
      cpu_act_q <= cpu_act;
      entry_q   <= 1'b0;
      done_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            // Read wins when both request lines are raised together.
            req_q.op    <= (bus.dma_write_req && !bus.dma_read_req) ? OP_WR : OP_RD;
            req_q.ma    <= bus.dma_ma;
            req_q.wdata <= bus.dma_wdata;
            cnt         <= '0;
            entry_q     <= 1'b1;
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cpu_act) begin
            cnt <= '0;
            if (preempt_first && (pcnt_q != '1)) begin
              pcnt_q <= pcnt_q + 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            if (req_q.op == OP_RD) begin
              rdata_q <= bus.ram_rdata;
            end
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Held level requests must drop before a new access can start.
          if (!any_req) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ram_addr  = req_q.ma;
    bus.ram_wdata = req_q.wdata;
    bus.ram_rd    = 1'b0;
    bus.ram_wr    = 1'b0;
    if (cpu_act) begin
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
      bus.ram_rd    = bus.cpu_rd;
      bus.ram_wr    = bus.cpu_wr;
    end else if (state == ST_ACCESS) begin
      bus.ram_rd = (req_q.op == OP_RD);
      bus.ram_wr = (req_q.op == OP_WR);
    end
  end

  assign bus.cpu_rdata     = bus.ram_rdata;
  assign bus.dma_rdata     = rdata_q;
  assign bus.dma_done      = done_q;
  assign bus.dma_busy      = (state == ST_ACCESS) || (state == ST_DONE);
  assign bus.preempt_count = pcnt_q;

endmodule

// File: tb/tb_pdp8_mem_arb.sv
// Scoreboard bench: the driver predicts each DMA completion from the CPU slot pattern,
// a negedge monitor checks the RAM bus every cycle and pops expectations on dma_done.
`timescale 1ns/1ps
module tb_pdp8_mem_arb;
  import pdp8_mem_pkg::*;

  localparam int RC = 2;
  localparam int PW = 8;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset;

  pdp8_mem_arb_if #(.PCNT_W(PW)) bus();

  pdp8_mem_arb #(.RAM_CYCLES(RC), .PCNT_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] init_word(input logic [14:0] a);
    logic [14:0] t;
    if (a == 15'o00200) return 12'o7402;
    if (a == 15'o10017) return 12'o1234;
    t = (a * 15'd7) ^ 15'o25252;
    return t[11:0];
  endfunction

  // Environment RAM: asynchronous read, write on the edge while ram_wr is high.
  logic [11:0] ram_mem [0:32767];
  bit          ram_vld [0:32767];
  assign bus.ram_rdata = ram_vld[bus.ram_addr] ? ram_mem[bus.ram_addr] : init_word(bus.ram_addr);
  always @(posedge clk) begin
    if (bus.ram_wr) begin
      ram_mem[bus.ram_addr] <= bus.ram_wdata;
      ram_vld[bus.ram_addr] <= 1'b1;
    end
  end

  typedef struct {
    bit          is_wr;
    logic [14:0] addr;
    logic [11:0] data;
    int          done_cyc;
    int          pcnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      logic act;
      exp_t e;
      act = bus.cpu_rd | bus.cpu_wr;
      chk("cpu_rdata", bus.cpu_rdata, bus.ram_rdata);
      if (act) begin
        chk("cpu_ram_addr", bus.ram_addr, bus.cpu_addr);
        chk("cpu_ram_rd", bus.ram_rd, bus.cpu_rd);
        chk("cpu_ram_wr", bus.ram_wr, bus.cpu_wr);
        if (bus.cpu_wr) chk("cpu_ram_wdata", bus.ram_wdata, bus.cpu_wdata);
      end else if (bus.ram_rd || bus.ram_wr) begin
        if (sb.size() == 0) begin
          flag("stray_dma_strobe");
        end else begin
          chk("dma_ram_addr", bus.ram_addr, sb[0].addr);
          chk("dma_ram_wr", bus.ram_wr, sb[0].is_wr);
          chk("dma_ram_rd", bus.ram_rd, !sb[0].is_wr);
          if (sb[0].is_wr) chk("dma_ram_wdata", bus.ram_wdata, sb[0].data);
        end
      end
      if (bus.dma_done) begin
        if (sb.size() == 0) begin
          flag("unexpected_dma_done");
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          if (!e.is_wr) chk("dma_rdata", bus.dma_rdata, e.data);
          chk("preempt_count", bus.preempt_count, e.pcnt);
        end
        done_cnt++;
      end
    end
  end

  // Reference state: memory contents and the saturating preemption count.
  logic [11:0] mem_ref [0:32767];
  int          pcnt_ref;

  bit          pat_busy [0:1023];
  bit          pat_wr   [0:1023];
  logic [14:0] pat_addr [0:1023];
  logic [11:0] pat_wd   [0:1023];
  int          pat_len;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input int i);
    if (i < pat_len && pat_busy[i]) begin
      bus.cpu_addr  = pat_addr[i];
      bus.cpu_wdata = pat_wd[i];
      bus.cpu_rd    = !pat_wr[i];
      bus.cpu_wr    = pat_wr[i];
      if (pat_wr[i]) mem_ref[pat_addr[i]] = pat_wd[i];
    end else begin
      bus.cpu_rd = 1'b0;
      bus.cpu_wr = 1'b0;
    end
  endtask

  task automatic pat_set(input int i, input bit wr, input logic [14:0] a, input logic [11:0] wd);
    pat_busy[i] = 1'b1;
    pat_wr[i]   = wr;
    pat_addr[i] = a;
    pat_wd[i]   = wd;
  endtask

  task automatic pat_clear(input int len);
    for (int i = 0; i < len; i++) pat_busy[i] = 1'b0;
    pat_len = len;
  endtask

  // CPU writes are kept in 07000..07077 so they never alias DMA targets.
  task automatic pat_rand(input int len, input int pct);
    pat_len = len;
    for (int i = 0; i < len; i++) begin
      pat_busy[i] = ($urandom_range(99) < pct);
      pat_wr[i]   = ($urandom_range(4) == 0);
      pat_addr[i] = pat_wr[i] ? (15'o07000 + 15'($urandom_range(63))) : 15'($urandom_range(32767));
      pat_wd[i]   = 12'($urandom_range(4095));
    end
  endtask

  // Issue one DMA request against the current CPU pattern (offset 0 = request cycle).
  task automatic run_xfer(input bit rd, input bit wr, input logic [14:0] a,
                          input logic [11:0] wd, input int hold);
    int   n, run, ep, done_off, start;
    exp_t e;
    next_cycle();
    next_cycle();
    n = cyc;
    bus.dma_ma        = a;
    bus.dma_wdata     = wd;
    bus.dma_read_req  = rd;
    bus.dma_write_req = wr;
    drive_cpu(0);
    // Completion needs RC consecutive CPU-free cycles after entry; each busy run is one episode.
    run = 0;
    ep = 0;
    done_off = 0;
    for (int i = 1; i < 4000 && done_off == 0; i++) begin
      if (i < pat_len && pat_busy[i]) begin
        run = 0;
        if (i == 1 || !pat_busy[i-1]) ep++;
      end else begin
        run++;
        if (run == RC) done_off = i + 1;
      end
    end
    pcnt_ref = (pcnt_ref + ep > PMAX) ? PMAX : pcnt_ref + ep;
    e.is_wr    = wr && !rd;
    e.addr     = a;
    e.data     = e.is_wr ? wd : mem_ref[a];
    e.done_cyc = n + done_off;
    e.pcnt     = pcnt_ref;
    sb.push_back(e);
    if (e.is_wr) mem_ref[a] = wd;
    start = done_cnt;
    for (int i = 1; done_cnt == start && i < 4000; i++) begin
      next_cycle();
      drive_cpu(i);
    end
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    if (done_cnt == start) flag("dma_done_timeout");
    for (int h = 0; h < hold; h++) begin
      chk("release_busy", bus.dma_busy, 1'b0);
      next_cycle();
    end
    bus.dma_read_req  = 1'b0;
    bus.dma_write_req = 1'b0;
  endtask

  task automatic cpu_read_chk(input logic [14:0] a);
    next_cycle();
    bus.cpu_addr = a;
    bus.cpu_rd   = 1'b1;
    #1;
    chk("cpu_rd_strobe", bus.ram_rd, 1'b1);
    chk("cpu_readback", bus.cpu_rdata, mem_ref[a]);
    chk("cpu_only_busy", bus.dma_busy, 1'b0);
    next_cycle();
    bus.cpu_rd = 1'b0;
  endtask

  initial begin
    reset             = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wdata     = '0;
    bus.cpu_rd        = 1'b0;
    bus.cpu_wr        = 1'b0;
    bus.dma_read_req  = 1'b0;
    bus.dma_write_req = 1'b0;
    bus.dma_ma        = '0;
    bus.dma_wdata     = '0;
    pcnt_ref          = 0;
    pat_len           = 0;
    for (int a = 0; a < 32768; a++) mem_ref[a] = init_word(15'(a));

    #12;
    chk("rst_busy", bus.dma_busy, 1'b0);
    chk("rst_done", bus.dma_done, 1'b0);
    chk("rst_pcnt", bus.preempt_count, 0);
    chk("rst_rdata", bus.dma_rdata, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_strobes", {bus.ram_rd, bus.ram_wr}, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();

    cpu_read_chk(15'o00200);

    pat_clear(0);
    run_xfer(1'b1, 1'b0, 15'o10017, 12'o0000, 0);

    pat_clear(3);
    pat_set(2, 1'b0, 15'o00200, 12'o0000);
    run_xfer(1'b0, 1'b1, 15'o00400, 12'o5555, 0);
    cpu_read_chk(15'o00400);

    pat_clear(0);
    run_xfer(1'b1, 1'b1, 15'o00017, 12'o7777, 3);
    cpu_read_chk(15'o00017);

    // Reset in the first ACCESS cycle abandons the read without a done pulse.
    pat_clear(0);
    next_cycle();
    next_cycle();
    bus.dma_ma       = 15'o00033;
    bus.dma_read_req = 1'b1;
    next_cycle();
    chk("pre_reset_strobe", bus.ram_rd, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", bus.dma_busy, 1'b0);
    chk("arst_done", bus.dma_done, 1'b0);
    chk("arst_strobes", {bus.ram_rd, bus.ram_wr}, 2'b00);
    chk("arst_ram_addr", bus.ram_addr, 0);
    chk("arst_pcnt", bus.preempt_count, 0);
    chk("arst_rdata", bus.dma_rdata, 0);
    bus.dma_read_req = 1'b0;
    pcnt_ref = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_xfer(1'b1, 1'b0, 15'o00033, 12'o0000, 0);

    // Long CPU bursts count once, whether they start before or at ACCESS entry.
    pat_clear(11);
    for (int i = 0; i < 11; i++) pat_set(i, 1'b0, 15'(i * 3), 12'o0000);
    run_xfer(1'b0, 1'b1, 15'o00041, 12'o1357, 0);
    pat_clear(11);
    for (int i = 1; i < 11; i++) pat_set(i, 1'b0, 15'(i * 5), 12'o0000);
    run_xfer(1'b1, 1'b0, 15'o00041, 12'o0000, 0);

    // 300 single-cycle preemptions inside one access saturate the counter.
    pat_clear(601);
    for (int i = 1; i < 600; i += 2) pat_set(i, 1'b0, 15'o00200, 12'o0000);
    run_xfer(1'b1, 1'b0, 15'o00002, 12'o0000, 0);
    pat_clear(3);
    pat_set(1, 1'b0, 15'o00200, 12'o0000);
    run_xfer(1'b0, 1'b1, 15'o00003, 12'o4321, 0);

    for (int t = 0; t < 40; t++) begin
      bit rd, wr;
      rd = $urandom_range(1) == 1;
      wr = !rd || ($urandom_range(3) == 0);
      pat_rand(40, 35);
      run_xfer(rd, wr, 15'($urandom_range(63)), 12'($urandom_range(4095)), $urandom_range(2));
    end

    for (int a = 0; a < 64; a++) cpu_read_chk(15'(a));

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pdp8_mem_arb.md
Name: pdp8_mem_arb

Overview:
- Arbiter between the CPU memory port and the IO data-break (DMA) port for the single pdp8_ram instance.
- Sits between pdp8 and pdp8_ram. The io/ext_ram_* request/done handshake from pdp8_io terminates here instead of in the CPU.
- The CPU has absolute priority and keeps zero-latency, unchanged timing.
- DMA accesses run in idle memory slots, are aborted and restarted when the CPU preempts, and are acknowledged with a one-cycle done pulse.

Parameters:
- RAM_CYCLES, 2, cycles ram_rd/ram_wr must be held for one DMA access (SRAM timing); legal range 1..15.
- PCNT_W, 8, width of the saturating preemption counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_addr  in  15  CPU address {IF/DF,addr}
- cpu_wdata  in  12  CPU write data
- cpu_rdata  out  12  read data to CPU
- cpu_rd  in  1  CPU read strobe (level)
- cpu_wr  in  1  CPU write strobe (level)
- dma_read_req  in  1  DMA read request, level, held until dma_done
- dma_write_req  in  1  DMA write request, level, held until dma_done
- dma_ma  in  15  DMA address
- dma_wdata  in  12  DMA write data
- dma_rdata  out  12  DMA read data, valid from the dma_done cycle until the next read completes
- dma_done  out  1  one-cycle completion pulse
- ram_addr  out  15  to pdp8_ram addr
- ram_wdata  out  12  to pdp8_ram data_in
- ram_rdata  in  12  from pdp8_ram data_out
- ram_rd  out  1  to pdp8_ram rd
- ram_wr  out  1  to pdp8_ram wr
- dma_busy  out  1  high in states ACCESS and DONE
- preempt_count  out  PCNT_W  saturating count of CPU preemptions of DMA accesses

Behaviour:

Reset:
- reset low: state=IDLE; cnt=0; op=0; latched ma/wdata=0; dma_rdata=0; dma_done=0; preempt_count=0.
- Combinational outputs follow from this state.
- Reset mid-access abandons the access with no done pulse. The requester must re-request.

CPU path (combinational):
- cpu_act = cpu_rd|cpu_wr.
- When cpu_act=1: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_rd=cpu_rd, ram_wr=cpu_wr.
- cpu_rdata=ram_rdata at all times.
- No added latency to CPU accesses.

DMA FSM (IDLE, ACCESS, DONE, RELEASE):
- IDLE:
  - On a clk edge with dma_read_req|dma_write_req: latch ma, wdata, op, set cnt=0, go to ACCESS.
  - op=write only if write_req && !read_req. When both requests are high, read wins.
- ACCESS, cpu_act=1:
  - ram_* show the CPU access; cnt<=0 (abort and restart).
  - preempt_count increments (saturating at all-ones) only on the first preempted cycle of each episode, i.e. when cpu_act was 0 the previous cycle or on ACCESS entry.
- ACCESS, cpu_act=0:
  - ram_addr=latched ma, ram_wdata=latched wdata; ram_rd=!op, ram_wr=op; cnt++.
  - When cnt==RAM_CYCLES-1: on a read, dma_rdata<=ram_rdata; go to DONE.
- DONE:
  - dma_done=1 for exactly one cycle; ram_rd=ram_wr=0 unless the CPU is active.
  - Next state RELEASE.
- RELEASE:
  - Wait until both requests are low, then go to IDLE. This prevents double service of a held level request.
- When no access is active, ram_rd=ram_wr=0 and ram_addr=latched ma.

Latency and ordering:
- Request first seen at edge k: ram strobes active cycles k+1 .. k+RAM_CYCLES (absent preemption); dma_done high in cycle k+RAM_CYCLES+1.
- Each preemption adds (preempted cycles + cycles already spent) to this latency.
- A DMA write never has ram_wr asserted in the same cycle as any CPU strobe.
- No partial DMA write is reported as done.
- If requests drop during ACCESS, the access still completes and pulses done (requester protocol violation is tolerated).

Decomposition:
- Shared package pdp8_mem_pkg:
  - FSM state encoding (2 bits: IDLE=0, ACCESS=1, DONE=2, RELEASE=3)
  - address width 15 and word width 12 constants
  - op encoding (RD=0, WR=1)
- Single module; no sub-module needed.
- The cnt width is derived from RAM_CYCLES via $clog2 (minimum 1).

Test Plan:
- CPU-only: cpu_rd at 15'o00200 with RAM word 12'o7402 -> ram_rd=1 in the same cycle, cpu_rdata=7402, no DMA state change.
- DMA read, CPU idle, RAM_CYCLES=2: dma_read_req at cycle 0 for ma 15'o10017 holding 12'o1234 -> ram_rd cycles 1-2, dma_done only in cycle 3, dma_rdata=1234, busy cycles 1-3.
- DMA write with cpu_rd asserted in cycle 2: write 12'o5555 to 15'o00400 -> cycle 2 shows CPU address, cnt restarts, ram_wr in cycles 3-4, done in cycle 5, preempt_count=1, later memory readback=5555.
- Both requests high together, held 3 cycles after done -> one read performed, single done pulse, FSM stays in RELEASE until the requests drop.
- reset driven low during ACCESS cycle 1 -> all outputs zero immediately (async), no done pulse; the re-request after release completes normally.
- 300 separate preemption episodes with PCNT_W=8 -> preempt_count saturates at 255; a continuous multi-cycle CPU burst counts only 1.
